// File: rtl/plms_adapt_ctrl.sv
// plms_adapt_ctrl
// Sequencer and weight-bank owner for the 8-element complex linear combiner
// of the PLMS beamformer. Holds 8 complex weights, applies saturating PLMS
// increments during a training run of n_train accepted updates, then freezes
// them. The host may write single weights while not training.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, n_train      begin a training run of n_train updates (IDLE/HOLD only)
//   abort               end the current run early, keep weights, no done
//   wr_en/addr/data     host single-weight write {wI, wQ}, index 0 is w1
//   x_valid             snapshot valid at combiner input
//   dw_valid, dw        increment vector {dw1I,dw1Q,...,dw8I,dw8Q}
//   w14, w58            packed weight buses {w1I,w1Q,...,w4I,w4Q} / {w5I..w8Q}
//   y_valid             x_valid delayed LC_LAT cycles
//   training, done      run in progress / one-cycle completion pulse
//   upd_cnt             updates applied in current or last run (saturating)
//   wr_err              one-cycle pulse for a host write rejected in TRAIN
module plms_adapt_ctrl #(
    parameter int DW     = 18,
    parameter int LC_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_train,
    input  logic               abort,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [2*DW-1:0]    wr_data,
    input  logic               x_valid,
    input  logic               dw_valid,
    input  logic [16*DW-1:0]   dw,
    output logic [8*DW-1:0]    w14,
    output logic [8*DW-1:0]    w58,
    output logic               y_valid,
    output logic               training,
    output logic               done,
    output logic [CNT_W-1:0]   upd_cnt,
    output logic               wr_err
);

    typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_HOLD} state_t;

    state_t                 r_state;
    logic signed [DW-1:0]   r_wc [16];   // component c: weight c/2, I when c even
    logic [CNT_W-1:0]       r_upd;
    logic [CNT_W-1:0]       r_target;
    logic                   r_training;
    logic                   r_done;
    logic                   r_wr_err;
    logic [LC_LAT-1:0]      r_vpipe;

    logic signed [DW-1:0]   w_sum [16];
    logic [CNT_W-1:0]       w_upd_inc;
    logic [3:0]             w_idx_i;
    logic [3:0]             w_idx_q;

    function automatic logic signed [DW-1:0] sat_add(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        // Top two bits disagree only on overflow; the carry-out bit gives the sign.
        if (s[DW] != s[DW-1])
            sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat_add = s[DW-1:0];
    endfunction

    always_comb begin
        for (int unsigned c = 0; c < 16; c++) begin
            w_sum[c] = sat_add(r_wc[c], dw[(16-c)*DW-1 -: DW]);
        end
    end

    always_comb begin
        w14 = '0;
        w58 = '0;
        for (int unsigned c = 0; c < 8; c++) begin
            w14[(8-c)*DW-1 -: DW] = r_wc[c];
            w58[(8-c)*DW-1 -: DW] = r_wc[c+8];
        end
    end

    assign w_upd_inc = (&r_upd) ? r_upd : r_upd + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_idx_i   = {wr_addr, 1'b0};
    assign w_idx_q   = {wr_addr, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_upd      <= '0;
            r_target   <= '0;
            r_training <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
            for (int unsigned c = 0; c < 16; c++) r_wc[c] <= '0;
        end else begin
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
            case (r_state)
                S_IDLE, S_HOLD: begin
                    // A write in the same cycle as start lands before training begins.
                    if (wr_en) begin
                        r_wc[w_idx_i] <= wr_data[2*DW-1:DW];
                        r_wc[w_idx_q] <= wr_data[DW-1:0];
                    end
                    if (start) begin
                        if (n_train != '0) begin
                            r_state    <= S_TRAIN;
                            r_training <= 1'b1;
                            r_upd      <= '0;
                            r_target   <= n_train;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_TRAIN: begin
                    if (wr_en) r_wr_err <= 1'b1;
                    if (abort) begin
                        r_state    <= S_HOLD;
                        r_training <= 1'b0;
                    end else if (dw_valid) begin
                        for (int unsigned c = 0; c < 16; c++) r_wc[c] <= w_sum[c];
                        r_upd <= w_upd_inc;
                        if (w_upd_inc == r_target) begin
                            r_state    <= S_HOLD;
                            r_training <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_training <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= x_valid;
            for (int unsigned i = 1; i < LC_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
        end
    end

    assign y_valid  = r_vpipe[LC_LAT-1];
    assign training = r_training;
    assign done     = r_done;
    assign upd_cnt  = r_upd;
    assign wr_err   = r_wr_err;

endmodule
